// File: rtl/hack_loader_pkg.sv
// hack_loader shared constants and state encoding.
// ASCII codes of the loader's input alphabet.
package hack_loader_pkg;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic {
    LD_LOAD = 1'b0,
    LD_DONE = 1'b1
  } ld_state_t;

endpackage

// File: rtl/hack_loader.sv
// hack_loader: ASCII '0'/'1' lines from uart_rx into instruction ROM,
// then release the Hack CPU from reset.
module hack_loader
  import hack_loader_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [WORD_WIDTH-1:0] rom_wdata,
  output logic                  rom_we,
  output logic                  cpu_reset,
  output logic                  loading,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int DW = $clog2(WORD_WIDTH + 2);
  localparam logic [DW-1:0] DIG_MAX = DW'(WORD_WIDTH);
  localparam logic [DW-1:0] DIG_SAT = DW'(WORD_WIDTH + 1);

  ld_state_t state, state_d;

  logic [WORD_WIDTH-1:0] shift;
  logic [DW-1:0]         digits;
  logic                  bad_line;
  logic [ADDR_WIDTH:0]   next_addr;

  logic active;
  logic take_bit;
  logic end_line;
  logic go_done;
  logic wr;
  logic ovf;
  logic bad_char;
  logic too_long;
  logic line_ok;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= LD_LOAD;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    take_bit = 1'b0;
    end_line = 1'b0;
    bad_char = 1'b0;
    active   = rx_valid && (state == LD_LOAD);
    if (active) begin
      unique case (1'b1)
        (rx_data == CH_0),
        (rx_data == CH_1):  take_bit = 1'b1;
        (rx_data == CH_LF): end_line = 1'b1;
        (rx_data == CH_CR): ;
        default:            bad_char = 1'b1;
      endcase
    end
    too_long = take_bit && (digits >= DIG_MAX);
    line_ok  = end_line && !bad_line;
    go_done  = line_ok && (digits == '0);
    // next_addr MSB set means every ROM slot is already used
    wr       = line_ok && (digits != '0) && !next_addr[ADDR_WIDTH];
    ovf      = line_ok && (digits != '0) && next_addr[ADDR_WIDTH];
    if (go_done) state_d = LD_DONE;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      shift     <= '0;
      digits    <= '0;
      bad_line  <= 1'b0;
      next_addr <= '0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      rom_we    <= 1'b0;
      error     <= 1'b0;
    end else begin
      rom_we <= wr;
      if (take_bit) begin
        shift <= {shift[WORD_WIDTH-2:0], rx_data[0]};
        if (digits != DIG_SAT) digits <= digits + DW'(1);
      end
      if (too_long || bad_char) bad_line <= 1'b1;
      if (wr) begin
        rom_wdata <= shift;
        rom_addr  <= next_addr[ADDR_WIDTH-1:0];
        next_addr <= next_addr + 1'b1;
      end
      if (end_line && !go_done) begin
        shift    <= '0;
        digits   <= '0;
        bad_line <= 1'b0;
      end
      if (too_long || bad_char || ovf) error <= 1'b1;
    end
  end

  assign words_loaded = next_addr;
  assign cpu_reset    = (state == LD_LOAD);
  assign loading      = (state == LD_LOAD);

endmodule
